// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream IMEM loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LEN_BYTES = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned WE_W      = 4;

    localparam logic [WE_W-1:0] MEM_WE_ALL = 4'hF;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words; flags the byte that completes a word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    localparam int unsigned SR_W = WORD_W - BYTE_W;

    logic [IDX_W-1:0] idx_q;
    logic [SR_W-1:0]  sr_q;

    // Completed word is presented in the same cycle its last byte is accepted.
    assign word_valid_c = en_i && (idx_q == IDX_W'(LEN_BYTES - 1));
    assign word_c       = {byte_i, sr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            sr_q  <= '0;
        end else if (en_i) begin
            idx_q <= idx_q + IDX_W'(1);
            sr_q  <= {byte_i, sr_q[SR_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives LEN|words|CSUM over a byte stream, writes BRAM port A,
// and releases the core from reset once the checksum verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic [WE_W-1:0]   mem_we,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  words_loaded
);

    state_e              state_q;
    logic                rx_ready_q;
    logic [WE_W-1:0]     mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [WORD_W-1:0]   mem_wdata_q;
    logic                cpu_rst_n_q;
    logic                done_q;
    logic                error_q;
    logic [CNT_W-1:0]    words_loaded_q;
    logic [31:0]         len_q;
    logic [BYTE_W-1:0]   csum_q;

    logic                accept_c;
    logic                pack_en_c;
    logic                word_valid_c;
    logic [WORD_W-1:0]   word_c;
    logic [CNT_W-1:0]    cnt_inc_c;

    assign accept_c  = rx_valid && rx_ready_q;
    assign pack_en_c = accept_c && ((state_q == S_LEN) || (state_q == S_DATA));
    assign cnt_inc_c = words_loaded_q + CNT_W'(1);

    // The length header and the payload words share one packer.
    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .en_i         (pack_en_c),
        .byte_i       (rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_LEN;
            rx_ready_q     <= 1'b1;
            mem_we_q       <= '0;
            mem_addr_q     <= BASE_ADDR;
            mem_wdata_q    <= '0;
            cpu_rst_n_q    <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
            len_q          <= '0;
            csum_q         <= '0;
        end else begin
            mem_we_q <= '0;
            if (pack_en_c) begin
                csum_q <= csum_q ^ rx_data;
            end

            unique case (state_q)
                S_LEN: begin
                    if (word_valid_c) begin
                        if (word_c > 32'(DEPTH_WORDS)) begin
                            state_q    <= S_ERR;
                            error_q    <= 1'b1;
                            rx_ready_q <= 1'b0;
                        end else if (word_c == 32'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            len_q   <= word_c;
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid_c) begin
                        mem_we_q       <= MEM_WE_ALL;
                        mem_addr_q     <= BASE_ADDR + (32'(words_loaded_q) << 2);
                        mem_wdata_q    <= word_c;
                        words_loaded_q <= cnt_inc_c;
                        if (32'(cnt_inc_c) == len_q) begin
                            state_q <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept_c) begin
                        rx_ready_q <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (state_q == S_DONE) begin
                        done_q      <= 1'b1;
                        cpu_rst_n_q <= 1'b1;
                    end
                    // Reload restarts the whole frame and re-asserts core reset.
                    if (reload) begin
                        state_q        <= S_LEN;
                        rx_ready_q     <= 1'b1;
                        mem_addr_q     <= BASE_ADDR;
                        cpu_rst_n_q    <= 1'b0;
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                        words_loaded_q <= '0;
                        len_q          <= '0;
                        csum_q         <= '0;
                    end
                end
                default: begin
                    state_q <= S_LEN;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized images against a frame-level model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ww_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] img_q[$];

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen on port A.
    always @(negedge clk) begin
        if (mem_we !== 4'h0) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            ww_q.push_back(mem_we);
        end
    end

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
        ww_q.delete();
    endtask

    // Frame = LEN (LE) | words (LE) | XOR of all preceding bytes.
    task automatic build_frame(input logic [31:0] n, input bit bad_csum);
        logic [7:0] x;
        frame_q.delete();
        for (int i = 0; i < 4; i++) frame_q.push_back(8'((n >> (8 * i)) & 32'hFF));
        foreach (img_q[k])
            for (int i = 0; i < 4; i++) frame_q.push_back(8'((img_q[k] >> (8 * i)) & 32'hFF));
        x = 8'h00;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        if (bad_csum) x = x ^ 8'h01;
        frame_q.push_back(x);
    endtask

    // Returns at the falling edge following the cycle in which the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit rand_reload);
        int t;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            reload   = rand_reload && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        reload   = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: rx_ready=%b required 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_range(input int first, input int last, input int maxgap, input bit rr);
        for (int i = first; i <= last; i++)
            send_byte(frame_q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, rr);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_writes();
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        clear_writes();
    endtask

    task automatic test_reset();
        do_reset();
        total += 8;
        if (rx_ready !== 1'b1)      begin bad++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        if (mem_we !== 4'h0)        begin bad++; $display("FAIL reset_mem_we: got %h want 0", mem_we); end
        if (mem_addr !== 32'h0)     begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        if (mem_wdata !== 32'h0)    begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        if (cpu_rst_n !== 1'b0)     begin bad++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n); end
        if (done !== 1'b0)          begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (error !== 1'b0)         begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        if (words_loaded !== 16'd0) begin bad++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
    endtask

    task automatic test_basic();
        img_q = '{32'h0000_0013, 32'h0010_0093};
        build_frame(32'd2, 1'b0);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], 0, 1'b0);
            if (i == 7 || i == 11) begin
                total += 4;
                if (mem_we !== 4'hF) begin bad++; $display("FAIL basic_we[%0d]: got %h want f", i, mem_we); end
                if (mem_addr !== ((i == 7) ? 32'h0 : 32'h4))
                    begin bad++; $display("FAIL basic_addr[%0d]: got %h", i, mem_addr); end
                if (mem_wdata !== ((i == 7) ? 32'h0000_0013 : 32'h0010_0093))
                    begin bad++; $display("FAIL basic_wdata[%0d]: got %h", i, mem_wdata); end
                if (words_loaded !== ((i == 7) ? 16'd1 : 16'd2))
                    begin bad++; $display("FAIL basic_words[%0d]: got %0d", i, words_loaded); end
            end
        end
        total += 2;
        if (done !== 1'b0)      begin bad++; $display("FAIL basic_done_early: got %b want 0", done); end
        if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL basic_rstn_early: got %b want 0", cpu_rst_n); end
        @(negedge clk);
        total += 5;
        if (done !== 1'b1)      begin bad++; $display("FAIL basic_done: got %b want 1", done); end
        if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL basic_rstn: got %b want 1", cpu_rst_n); end
        if (error !== 1'b0)     begin bad++; $display("FAIL basic_error: got %b want 0", error); end
        if (rx_ready !== 1'b0)  begin bad++; $display("FAIL basic_rx_ready: got %b want 0", rx_ready); end
        if (wa_q.size() != 2)   begin bad++; $display("FAIL basic_write_count: got %0d want 2", wa_q.size()); end
    endtask

    task automatic test_reload();
        do_reload();
        total += 5;
        if (cpu_rst_n !== 1'b0)     begin bad++; $display("FAIL reload_rstn: got %b want 0", cpu_rst_n); end
        if (done !== 1'b0)          begin bad++; $display("FAIL reload_done: got %b want 0", done); end
        if (error !== 1'b0)         begin bad++; $display("FAIL reload_error: got %b want 0", error); end
        if (rx_ready !== 1'b1)      begin bad++; $display("FAIL reload_rx_ready: got %b want 1", rx_ready); end
        if (words_loaded !== 16'd0) begin bad++; $display("FAIL reload_words: got %0d want 0", words_loaded); end
        img_q = '{$urandom};
        build_frame(32'd1, 1'b0);
        send_range(0, 5, 2, 1'b0);
        total++;
        if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL reload_rstn_loading: got %b want 0", cpu_rst_n); end
        send_range(6, frame_q.size() - 1, 2, 1'b0);
        @(negedge clk);
        total += 4;
        if (done !== 1'b1) begin bad++; $display("FAIL reload_final_done: got %b want 1", done); end
        if (wa_q.size() != 1) begin
            bad++; $display("FAIL reload_write_count: got %0d want 1", wa_q.size());
        end else begin
            if (wa_q[0] !== 32'h0)     begin bad++; $display("FAIL reload_addr: got %h want 0", wa_q[0]); end
            if (wd_q[0] !== img_q[0])  begin bad++; $display("FAIL reload_wdata: got %h want %h", wd_q[0], img_q[0]); end
        end
    endtask

    task automatic test_bad_csum();
        do_reload();
        img_q = '{32'h0000_0013, 32'h0010_0093};
        build_frame(32'd2, 1'b1);
        send_range(0, frame_q.size() - 1, 0, 1'b0);
        total += 4;
        if (error !== 1'b1)    begin bad++; $display("FAIL badcs_error: got %b want 1", error); end
        if (done !== 1'b0)     begin bad++; $display("FAIL badcs_done: got %b want 0", done); end
        if (rx_ready !== 1'b0) begin bad++; $display("FAIL badcs_rx_ready: got %b want 0", rx_ready); end
        if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL badcs_rstn: got %b want 0", cpu_rst_n); end
        repeat (3) @(negedge clk);
        total += 2;
        if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL badcs_rstn_hold: got %b want 0", cpu_rst_n); end
        if (done !== 1'b0)      begin bad++; $display("FAIL badcs_done_hold: got %b want 0", done); end
    endtask

    task automatic test_empty();
        do_reload();
        img_q.delete();
        build_frame(32'd0, 1'b0);
        send_range(0, frame_q.size() - 1, 1, 1'b0);
        @(negedge clk);
        total += 4;
        if (done !== 1'b1)          begin bad++; $display("FAIL empty_done: got %b want 1", done); end
        if (cpu_rst_n !== 1'b1)     begin bad++; $display("FAIL empty_rstn: got %b want 1", cpu_rst_n); end
        if (words_loaded !== 16'd0) begin bad++; $display("FAIL empty_words: got %0d want 0", words_loaded); end
        if (wa_q.size() != 0)       begin bad++; $display("FAIL empty_writes: got %0d want 0", wa_q.size()); end
    endtask

    task automatic test_oversize();
        do_reload();
        img_q.delete();
        build_frame(32'd1025, 1'b0);
        send_range(0, 2, 0, 1'b0);
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL over_error_early: got %b want 0", error); end
        send_byte(frame_q[3], 0, 1'b0);
        total += 3;
        if (error !== 1'b1)    begin bad++; $display("FAIL over_error: got %b want 1", error); end
        if (rx_ready !== 1'b0) begin bad++; $display("FAIL over_rx_ready: got %b want 0", rx_ready); end
        if (done !== 1'b0)     begin bad++; $display("FAIL over_done: got %b want 0", done); end
        repeat (2) @(negedge clk);
        total += 2;
        if (wa_q.size() != 0)   begin bad++; $display("FAIL over_writes: got %0d want 0", wa_q.size()); end
        if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL over_rstn: got %b want 0", cpu_rst_n); end
    endtask

    task automatic test_rst_midword();
        do_reset();
        img_q = '{$urandom, $urandom, $urandom};
        build_frame(32'd3, 1'b0);
        send_range(0, 5, 3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total += 4;
        if (wa_q.size() != 0)       begin bad++; $display("FAIL rstmid_writes: got %0d want 0", wa_q.size()); end
        if (rx_ready !== 1'b1)      begin bad++; $display("FAIL rstmid_rx_ready: got %b want 1", rx_ready); end
        if (words_loaded !== 16'd0) begin bad++; $display("FAIL rstmid_words: got %0d want 0", words_loaded); end
        if (error !== 1'b0)         begin bad++; $display("FAIL rstmid_error: got %b want 0", error); end
        img_q = '{$urandom, $urandom};
        build_frame(32'd2, 1'b0);
        send_range(0, frame_q.size() - 1, 3, 1'b0);
        @(negedge clk);
        total += 2;
        if (done !== 1'b1) begin bad++; $display("FAIL rstmid_done: got %b want 1", done); end
        if (wa_q.size() != 2) begin
            bad++; $display("FAIL rstmid_write_count: got %0d want 2", wa_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (wa_q[k] !== 32'(4 * k) || wd_q[k] !== img_q[k]) begin
                    bad++;
                    $display("FAIL rstmid_write[%0d]: got %h/%h want %h/%h", k, wa_q[k], wd_q[k], 32'(4 * k), img_q[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int unsigned n;
            bit          corrupt;
            do_reload();
            n       = $urandom_range(1, 6);
            corrupt = ($urandom_range(0, 3) == 0);
            img_q.delete();
            for (int k = 0; k < int'(n); k++) img_q.push_back($urandom);
            build_frame(32'(n), corrupt);
            send_range(0, frame_q.size() - 1, (it % 2 == 0) ? 0 : 3, 1'b1);
            total++;
            if (error !== corrupt) begin bad++; $display("FAIL rand%0d_error: got %b want %b", it, error, corrupt); end
            @(negedge clk);
            total += 4;
            if (done !== !corrupt)      begin bad++; $display("FAIL rand%0d_done: got %b want %b", it, done, !corrupt); end
            if (cpu_rst_n !== !corrupt) begin bad++; $display("FAIL rand%0d_rstn: got %b want %b", it, cpu_rst_n, !corrupt); end
            if (words_loaded !== 16'(n)) begin bad++; $display("FAIL rand%0d_words: got %0d want %0d", it, words_loaded, n); end
            if (wa_q.size() != int'(n)) begin
                bad++; $display("FAIL rand%0d_write_count: got %0d want %0d", it, wa_q.size(), n);
            end else begin
                for (int k = 0; k < int'(n); k++) begin
                    total++;
                    if (ww_q[k] !== 4'hF || wa_q[k] !== 32'(4 * k) || wd_q[k] !== img_q[k]) begin
                        bad++;
                        $display("FAIL rand%0d_write[%0d]: got we=%h %h/%h want we=f %h/%h",
                                 it, k, ww_q[k], wa_q[k], wd_q[k], 32'(4 * k), img_q[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_bad_csum();
        test_empty();
        test_oversize();
        test_rst_midword();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
